// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: per-digit hex/blank register file,
// single shared decoder, fixed-length digit slots with a leading blanking gap.
module seg_scan_ctrl #(
   parameter int N_DIGITS     = 4,
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        wr_en,
   input  logic [$clog2(N_DIGITS)-1:0] wr_addr,
   input  logic [3:0]                  wr_data,
   input  logic                        wr_blank,
   output logic [6:0]                  seg,
   output logic [N_DIGITS-1:0]         an,
   output logic                        frame_done
);

   localparam int AW = $clog2(N_DIGITS);
   localparam int CW = $clog2(PRESCALE);
   localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);
   localparam logic [AW-1:0] IDX_MAX = AW'(N_DIGITS - 1);
   localparam logic [N_DIGITS-1:0] ONE = {{(N_DIGITS-1){1'b0}}, 1'b1};

   typedef enum logic {ST_BLANK, ST_ON} st_e;

   st_e                        st_q, st_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic [AW-1:0]              idx_q, idx_d;
   logic [N_DIGITS-1:0][3:0]   val_q;
   logic [N_DIGITS-1:0]        blk_q;
   logic [6:0]                 seg_q;
   logic [N_DIGITS-1:0]        an_q;
   logic                       frame_q;
   logic                       slot_end, wrap, wr_ok;

   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'h0: decode = 7'h3F;
         4'h1: decode = 7'h06;
         4'h2: decode = 7'h5B;
         4'h3: decode = 7'h4F;
         4'h4: decode = 7'h66;
         4'h5: decode = 7'h6D;
         4'h6: decode = 7'h7D;
         4'h7: decode = 7'h07;
         4'h8: decode = 7'h7F;
         4'h9: decode = 7'h6F;
         4'hA: decode = 7'h77;
         4'hB: decode = 7'h7C;
         4'hC: decode = 7'h39;
         4'hD: decode = 7'h5E;
         4'hE: decode = 7'h79;
         default: decode = 7'h71;
      endcase
   endfunction

   always_comb begin
      slot_end = (cnt_q == CNT_MAX);
      wrap     = slot_end && (idx_q == IDX_MAX);
      cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
      idx_d    = idx_q;
      if (slot_end) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      st_d = st_q;
      case (st_q)
         ST_BLANK: if (cnt_d == BLANK_C) st_d = ST_ON;
         ST_ON:    if (slot_end) st_d = ST_BLANK;
         default:  st_d = ST_BLANK;
      endcase
      wr_ok = wr_en && (32'(wr_addr) < N_DIGITS);
   end

   // Outputs look at next-state position but the already-registered digit
   // data, giving a one-edge write-to-display latency.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q    <= ST_BLANK;
         cnt_q   <= '0;
         idx_q   <= '0;
         val_q   <= '0;
         blk_q   <= '1;
         seg_q   <= 7'h7F;
         an_q    <= '1;
         frame_q <= 1'b0;
      end else begin
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         frame_q <= wrap;
         if (wr_ok) begin
            val_q[wr_addr] <= wr_data;
            blk_q[wr_addr] <= wr_blank;
         end
         if (st_d == ST_ON && !blk_q[idx_d]) begin
            an_q  <= ~(ONE << idx_d);
            seg_q <= ~decode(val_q[idx_d]);
         end else begin
            an_q  <= '1;
            seg_q <= 7'h7F;
         end
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign frame_done = frame_q;

endmodule
